// File: rtl/pipe_scoreboard_pkg.sv
// Shared constants and types for the pipeline scoreboard (pipe_scoreboard).
// Result-ready stage indices and the register-file forwarding select.
package pipe_pkg;

    localparam int unsigned RDY_ALU         = 2;
    localparam int unsigned MEM_LAT_DEFAULT = 1;
    localparam int unsigned RDY_LOAD        = RDY_ALU + MEM_LAT_DEFAULT;
    localparam int unsigned SEL_REGFILE     = 0;

    typedef enum logic {
        PROD_ALU  = 1'b0,
        PROD_LOAD = 1'b1
    } prod_kind_e;

    // Stage index at which a producer's result first sits in a pipeline register.
    function automatic int unsigned rdy_of(prod_kind_e kind, int unsigned mem_lat);
        return (kind == PROD_LOAD) ? (RDY_ALU + mem_lat) : RDY_ALU;
    endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// Issue/forwarding bundle between the ID stage and pipe_scoreboard.
// Optional SCB_STALL_CNT_EN adds the saturating stall_cnt observation signal.
interface pipe_scoreboard_if #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3
);

    localparam int unsigned SEL_W = $clog2(DEPTH + 1);

    logic                          issue_valid;
    logic                          issue_wr;
    logic                          issue_is_load;
    logic [REG_ADDR_W-1:0]         issue_dst;
    logic [NUM_SRC*REG_ADDR_W-1:0] src_addr;
    logic [NUM_SRC-1:0]            src_used;
    logic                          flush;
    logic                          stall;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;

`ifdef SCB_STALL_CNT_EN
    logic [31:0]                   stall_cnt;

    modport master (
        output issue_valid, issue_wr, issue_is_load, issue_dst,
        output src_addr, src_used, flush,
        input  stall, fwd_sel, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_wr, issue_is_load, issue_dst,
        input  src_addr, src_used, flush,
        output stall, fwd_sel, stall_cnt
    );
`else
    modport master (
        output issue_valid, issue_wr, issue_is_load, issue_dst,
        output src_addr, src_used, flush,
        input  stall, fwd_sel
    );

    modport slave (
        input  issue_valid, issue_wr, issue_is_load, issue_dst,
        input  src_addr, src_used, flush,
        output stall, fwd_sel
    );
`endif

endinterface

// File: rtl/pipe_scoreboard_src_check.sv
// Per-operand producer search: youngest matching in-flight write decides the
// forwarding select or raises a load-use hazard.
module scb_src_check
    import pipe_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned RDY_W      = 2
) (
    input  logic                             i_used,
    input  logic [REG_ADDR_W-1:0]            i_addr,
    input  logic [DEPTH-1:0]                 i_valid,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0] i_dst,
    input  logic [DEPTH-1:0][RDY_W-1:0]      i_rdy,
    output logic [SEL_W-1:0]                 o_sel,
    output logic                             o_hazard
);

    logic w_found;
    logic w_ready;

    // Index s holds stage s+1; the consumer meets that producer at stage s+2.
    always_comb begin
        o_sel    = '0;
        o_hazard = 1'b0;
        w_found  = 1'b0;
        w_ready  = 1'b0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            w_ready = ((s + 2) >= 32'(i_rdy[s]));
            if (!w_found && i_used && i_valid[s] &&
                (i_dst[s] == i_addr) && (i_addr != '0)) begin
                w_found = 1'b1;
                if (s == DEPTH - 1) begin
                    o_sel = SEL_W'(SEL_REGFILE);
                end else if (w_ready) begin
                    o_sel = SEL_W'(s + 2);
                end else begin
                    o_hazard = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_scoreboard.sv
// Parametrised hazard/forwarding scoreboard tracking DEPTH stages after ID.
// Define SCB_STALL_CNT_EN to add a saturating 32-bit stall cycle counter.
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned MEM_LAT    = MEM_LAT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    pipe_scoreboard_if.slave bus
);

    localparam int unsigned SEL_W = $clog2(DEPTH + 1);
    localparam int unsigned RDY_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic [RDY_W-1:0]      rdy;
    } entry_t;

    entry_t                           r_entry [DEPTH];
    logic [NUM_SRC*SEL_W-1:0]         r_fwd_sel;

    entry_t                           w_new_entry;
    prod_kind_e                       w_kind;
    logic [DEPTH-1:0]                 w_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] w_dst;
    logic [DEPTH-1:0][RDY_W-1:0]      w_rdy;
    logic [NUM_SRC*SEL_W-1:0]         w_sel;
    logic [NUM_SRC-1:0]               w_hazard;
    logic                             w_stall;
    logic                             w_accept;

    always_comb begin
        w_valid = '0;
        w_dst   = '0;
        w_rdy   = '0;
        for (int unsigned s = 0; s < DEPTH; s++) begin
            w_valid[s] = r_entry[s].valid;
            w_dst[s]   = r_entry[s].dst;
            w_rdy[s]   = r_entry[s].rdy;
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        scb_src_check #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W),
            .RDY_W      (RDY_W)
        ) u_chk (
            .i_used   (bus.src_used[i]),
            .i_addr   (bus.src_addr[i*REG_ADDR_W +: REG_ADDR_W]),
            .i_valid  (w_valid),
            .i_dst    (w_dst),
            .i_rdy    (w_rdy),
            .o_sel    (w_sel[i*SEL_W +: SEL_W]),
            .o_hazard (w_hazard[i])
        );
    end

    // Flush dominates a hazard: the killed instruction becomes a bubble.
    assign w_stall  = bus.issue_valid & ~bus.flush & (|w_hazard);
    assign w_accept = bus.issue_valid & ~w_stall & ~bus.flush;
    assign w_kind   = bus.issue_is_load ? PROD_LOAD : PROD_ALU;

    always_comb begin
        w_new_entry       = '0;
        w_new_entry.valid = w_accept & bus.issue_wr;
        w_new_entry.dst   = bus.issue_dst;
        w_new_entry.rdy   = RDY_W'(rdy_of(w_kind, MEM_LAT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < DEPTH; s++) begin
                r_entry[s] <= '0;
            end
            r_fwd_sel <= '0;
        end else begin
            r_entry[0] <= w_new_entry;
            for (int unsigned s = 1; s < DEPTH; s++) begin
                r_entry[s] <= r_entry[s-1];
            end
            r_fwd_sel <= w_accept ? w_sel : '0;
        end
    end

    assign bus.stall   = w_stall;
    assign bus.fwd_sel = r_fwd_sel;

`ifdef SCB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule
